// File: rtl/mutex_merge_pkg.sv
// Shared types and constants for the N-channel drive/free merge.
package mutex_merge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/mutex_merge_n_rr_arb.sv
// Combinational arbiter: fixed priority or round-robin from ptr+1, via a
// double-width masked lowest-set-bit search so the wrap needs no special case.
module rr_arb_n
  import mutex_merge_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int MODE = MODE_FIXED,
  localparam int IW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [2*N_CH-1:0] dbl_req;
  logic [2*N_CH-1:0] dbl_mask;
  logic [2*N_CH-1:0] dbl_hit;
  int                start;

  always_comb begin
    start = 0;
    if (MODE == MODE_RR) begin
      start = (int'(ptr) == N_CH - 1) ? 0 : int'(ptr) + 1;
    end
    dbl_req  = {req, req};
    dbl_mask = '0;
    for (int i = 0; i < 2 * N_CH; i++) begin
      dbl_mask[i] = (i >= start);
    end
    dbl_hit = dbl_req & dbl_mask;
    // Upper copy holds every request, so a hit exists whenever req != 0.
    idx = '0;
    for (int i = 2 * N_CH - 1; i >= 0; i--) begin
      if (dbl_hit[i]) idx = IW'(i % N_CH);
    end
    any   = |req;
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mutex_merge_n.sv
// Clocked N-channel merge: arbitrates drive pulses onto one downstream stage,
// keeps losers pending, and returns the downstream free to the owning channel.
module mutex_merge_n
  import mutex_merge_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int MODE = MODE_FIXED,
  localparam int IW = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_drive,
  output logic [N_CH-1:0] o_free,
  output logic            o_driveNext,
  input  logic            i_freeNext,
  output logic [IW-1:0]   o_owner,
  output logic            o_busy,
  output logic            o_err,
  output state_t          dbg_state
);

  // Handshake: a one-cycle i_drive[k] pulse is a request; it is answered by a
  // one-cycle o_free[k] pulse. Downstream sees one o_driveNext pulse per grant
  // and answers with one i_freeNext pulse (allowed in the o_driveNext cycle).
  state_t          state, state_d;
  logic [N_CH-1:0] pending, pending_d;
  logic [N_CH-1:0] owner_mask, req, win_grant, free_d;
  logic [IW-1:0]   owner_d, rr_ptr, rr_ptr_d, win_idx;
  logic            win_any, drive_d, err_d;

  rr_arb_n #(.N_CH(N_CH), .MODE(MODE)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    owner_mask = '0;
    if (state == BUSY) owner_mask[o_owner] = 1'b1;
    // Drives on an already-pending channel or on the owner are dropped.
    req       = pending | (i_drive & ~pending & ~owner_mask);
    err_d     = o_err | (|(i_drive & (pending | owner_mask))) |
                (i_freeNext && (state == IDLE));
    state_d   = state;
    pending_d = pending;
    owner_d   = o_owner;
    rr_ptr_d  = rr_ptr;
    drive_d   = 1'b0;
    free_d    = '0;
    case (state)
      IDLE: begin
        if (win_any) begin
          owner_d   = win_idx;
          rr_ptr_d  = win_idx;
          pending_d = req & ~win_grant;
          drive_d   = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        pending_d = req;
        if (i_freeNext) begin
          free_d  = owner_mask;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pending     <= '0;
      o_owner     <= '0;
      rr_ptr      <= IW'(N_CH - 1);
      o_driveNext <= 1'b0;
      o_free      <= '0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_d;
      pending     <= pending_d;
      o_owner     <= owner_d;
      rr_ptr      <= rr_ptr_d;
      o_driveNext <= drive_d;
      o_free      <= free_d;
      o_err       <= err_d;
    end
  end

  assign o_busy    = (state == BUSY);
  assign dbg_state = state;

endmodule

// File: tb/tb_mutex_merge_n.sv
// Bench for mutex_merge_n: fixed-priority and round-robin instances on shared
// stimulus, checked against a set-based reference model and directed vectors.
module tb_mutex_merge_n;
  import mutex_merge_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i_drive;
  logic         i_freeNext;
  logic [N-1:0] free_w [2];
  logic         drv_w  [2];
  logic [1:0]   owner_w[2];
  logic         busy_w [2];
  logic         err_w  [2];
  state_t       st_w   [2];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state, index 0 = fixed priority, 1 = round-robin
  logic [N-1:0] m_pend [2];
  bit           m_busy [2];
  int           m_owner[2];
  int           m_rr   [2];
  bit           m_err  [2];
  logic [N-1:0] e_free [2];
  bit           e_drv  [2];

  logic [1:0] got0[$];
  logic [1:0] got1[$];
  logic [1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] d;
    logic         f;
    logic         e_drv;
    logic [1:0]   e_owner;
    logic         e_busy;
    logic [N-1:0] e_free;
  } vec_t;
  vec_t vecs[13];

  mutex_merge_n #(.N_CH(N), .MODE(MODE_FIXED)) u_fixed (
    .clk(clk), .rst(rst), .i_drive(i_drive), .o_free(free_w[0]),
    .o_driveNext(drv_w[0]), .i_freeNext(i_freeNext), .o_owner(owner_w[0]),
    .o_busy(busy_w[0]), .o_err(err_w[0]), .dbg_state(st_w[0])
  );

  mutex_merge_n #(.N_CH(N), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst(rst), .i_drive(i_drive), .o_free(free_w[1]),
    .o_driveNext(drv_w[1]), .i_freeNext(i_freeNext), .o_owner(owner_w[1]),
    .o_busy(busy_w[1]), .o_err(err_w[1]), .dbg_state(st_w[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int m, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [inst %0d] t=%0t: got %0h expected %0h", name, m, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = '0;
      m_busy[m]  = 0;
      m_owner[m] = 0;
      m_rr[m]    = N - 1;
      m_err[m]   = 0;
      e_free[m]  = '0;
      e_drv[m]   = 0;
    end
  endtask

  // Requests form a set; a grant takes the first member in search order.
  task automatic model_step(input logic [N-1:0] d, input logic f);
    for (int m = 0; m < 2; m++) begin
      bit was_busy;
      int w;
      int k;
      was_busy  = m_busy[m];
      w         = -1;
      e_free[m] = '0;
      e_drv[m]  = 0;
      for (int j = 0; j < N; j++) begin
        if (d[j]) begin
          if (m_pend[m][j] || (was_busy && m_owner[m] == j)) m_err[m] = 1;
          else m_pend[m][j] = 1'b1;
        end
      end
      if (!was_busy) begin
        if (f) m_err[m] = 1;
        for (int s = 0; s < N; s++) begin
          k = (m == 0) ? s : (m_rr[m] + 1 + s) % N;
          if (w < 0 && m_pend[m][k]) w = k;
        end
        if (w >= 0) begin
          m_pend[m][w] = 1'b0;
          m_owner[m]   = w;
          m_rr[m]      = w;
          m_busy[m]    = 1;
          e_drv[m]     = 1;
        end
      end else if (f) begin
        e_free[m][m_owner[m]] = 1'b1;
        m_busy[m] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk("o_free", m, free_w[m], e_free[m]);
      chk("o_driveNext", m, drv_w[m], e_drv[m]);
      chk("o_busy", m, busy_w[m], m_busy[m]);
      chk("o_owner", m, owner_w[m], m_owner[m]);
      chk("o_err", m, err_w[m], m_err[m]);
      chk("dbg_state", m, (st_w[m] == BUSY), m_busy[m]);
    end
    if (drv_w[0]) got0.push_back(owner_w[0]);
    if (drv_w[1]) got1.push_back(owner_w[1]);
  endtask

  task automatic check_zero(input string name);
    for (int m = 0; m < 2; m++) begin
      chk({name, "_free"}, m, free_w[m], 0);
      chk({name, "_drv"}, m, drv_w[m], 0);
      chk({name, "_busy"}, m, busy_w[m], 0);
      chk({name, "_owner"}, m, owner_w[m], 0);
      chk({name, "_err"}, m, err_w[m], 0);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked one cycle later.
  task automatic tick(input logic [N-1:0] d, input logic f);
    i_drive    = d;
    i_freeNext = f;
    model_step(d, f);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    i_drive    = '0;
    i_freeNext = 1'b0;
    rst        = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero("rst");
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] d;
    logic         f;
    int           ones;

    vecs[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
    vecs[2]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
    vecs[4]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0100};
    vecs[6]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
    vecs[7]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
    vecs[8]  = '{4'b1000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
    vecs[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0001};
    vecs[10] = '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000};
    vecs[11] = '{4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 4'b1000};
    vecs[12] = '{4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000};

    // reset held with random inputs
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      i_drive    = N'($urandom);
      i_freeNext = 1'($urandom);
      @(negedge clk);
      check_zero("reset_hold");
    end
    i_drive    = '0;
    i_freeNext = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick('0, 1'b0);
      chk("idle_no_drive", 0, drv_w[0] | drv_w[1], 0);
    end

    // single request, then overlap with a zero-latency free
    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].d, vecs[i].f);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("vec%0d_drv", i), m, drv_w[m], vecs[i].e_drv);
        chk($sformatf("vec%0d_owner", i), m, owner_w[m], vecs[i].e_owner);
        chk($sformatf("vec%0d_busy", i), m, busy_w[m], vecs[i].e_busy);
        chk($sformatf("vec%0d_free", i), m, free_w[m], vecs[i].e_free);
      end
    end

    // simultaneous 1011 after a ch0 grant leaves rr_ptr at 0
    do_reset();
    tick(4'b0001, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);
    got0.delete();
    got1.delete();
    tick(4'b1011, 1'b0);
    for (int g = 0; g < 3; g++) begin
      tick(4'b0000, 1'b0);
      tick(4'b0000, 1'b1);
      tick(4'b0000, 1'b0);
    end
    exp_q.delete();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    chk("fixed_grant_count", 0, got0.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got0.size(); i++)
      chk("fixed_grant_order", 0, got0[i], exp_q[i]);
    exp_q.delete();
    exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    chk("rr_grant_count", 1, got1.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got1.size(); i++)
      chk("rr_grant_order", 1, got1[i], exp_q[i]);

    // repeated drive while pending
    do_reset();
    got0.delete();
    tick(4'b0001, 1'b0);
    tick(4'b0010, 1'b0);
    tick(4'b0010, 1'b0);
    chk("err_repeat", 0, err_w[0], 1);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    ones = 0;
    foreach (got0[i]) if (got0[i] == 2'd1) ones++;
    chk("one_grant_ch1", 0, ones, 1);

    // free while idle
    do_reset();
    tick(4'b0000, 1'b1);
    chk("err_free_idle", 0, err_w[0], 1);
    chk("no_free_idle", 0, free_w[0], 0);

    // reset while busy with two pending
    do_reset();
    tick(4'b0001, 1'b0);
    tick(4'b0110, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_zero("mid_reset");
    model_reset();
    i_drive = '0;
    i_freeNext = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(4'b0100, 1'b0);
    chk("post_reset_drv", 0, drv_w[0], 1);
    chk("post_reset_owner", 0, owner_w[0], 2);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);

    // random traffic: legal-only blocks, then unrestricted blocks
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        for (int k = 0; k < N; k++) d[k] = ($urandom_range(0, 5) == 0);
        f = ($urandom_range(0, 2) == 0);
        if (blk < 2) begin
          d = d & ~m_pend[0];
          if (m_busy[0]) d[m_owner[0]] = 1'b0;
          if (!m_busy[0]) f = 1'b0;
          if (m_busy[1]) d[m_owner[1]] = 1'b0;
          d = d & ~m_pend[1];
          if (!m_busy[1]) f = 1'b0;
        end
        tick(d, f);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
